// File: rtl/freq_list_sorter_pkg.sv
// Shared widths, the (symbol, frequency) slot record and the sorter FSM states
// for the literal/length frequency sorting stage.
package freq_list_sorter_pkg;

  localparam int NUM_LITLEN_SYMBOLS = 286;
  localparam int SYM_W              = 9;
  localparam int FREQ_W             = 16;

  typedef struct packed {
    logic [SYM_W-1:0]  sym;
    logic [FREQ_W-1:0] freq;
    logic              vld;
  } sym_freq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/freq_list_sorter_if.sv
// Frequency-memory read port plus the sorted-pair output stream of the sorter.
interface freq_list_sorter_if;
  import freq_list_sorter_pkg::*;

  logic              freq_rd_en;
  logic [SYM_W-1:0]  freq_rd_addr;
  logic [FREQ_W-1:0] freq_rd_data;

  // Stream handshake: a pair transfers on a rising edge where out_valid && out_ready.
  // Once out_valid is high, out_sym/out_freq/out_last hold until that transfer;
  // out_valid never depends combinationally on out_ready.
  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic [FREQ_W-1:0] out_freq;
  logic              out_last;

  modport master (
    output freq_rd_en, freq_rd_addr,
    input  freq_rd_data,
    output out_valid, out_sym, out_freq, out_last,
    input  out_ready
  );

  modport slave (
    input  freq_rd_en, freq_rd_addr,
    output freq_rd_data,
    input  out_valid, out_sym, out_freq, out_last,
    output out_ready
  );

endinterface

// File: rtl/freq_list_sorter_sort_slot.sv
// One register of the insertion-sort array: holds a (symbol, freq) pair and
// takes the new pair, the pair below (insert shift-up) or the pair above (drain).
module freq_list_sorter_sort_slot
  import freq_list_sorter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      ins_en,
  input  logic      shift_dn,
  input  sym_freq_t ins_pair,
  input  sym_freq_t below_pair,
  input  logic      below_gt,
  input  sym_freq_t above_pair,
  output sym_freq_t pair,
  output logic      gt
);

  // Strictly greater keeps equal frequencies in arrival (ascending symbol) order.
  assign gt = !pair.vld || (pair.freq > ins_pair.freq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair <= '0;
    end else if (clear) begin
      pair <= '0;
    end else if (ins_en) begin
      if (below_gt) begin
        pair <= below_pair;
      end else if (gt) begin
        pair <= ins_pair;
      end
    end else if (shift_dn) begin
      pair <= above_pair;
    end
  end

endmodule

// File: rtl/freq_list_sorter.sv
// Scans the literal/length frequency memory, insertion-sorts the nonzero
// entries by ascending frequency and streams them to the tree builder.
module freq_list_sorter
  import freq_list_sorter_pkg::*;
#(
  parameter int NUM_SYMBOLS = NUM_LITLEN_SYMBOLS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  freq_list_sorter_if.master  bus,
  output logic [SYM_W:0]      nz_count,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);

  localparam logic [SYM_W-1:0] LAST_ADDR = SYM_W'(NUM_SYMBOLS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SYM_W-1:0] addr_q;
  logic [SYM_W:0]   rd_ptr_q;
  logic             pend_vld_q;
  logic [SYM_W-1:0] pend_sym_q;

  logic             clear;
  logic             rd_en;
  logic             drained;
  logic             out_valid;
  logic             hs;
  logic             ins_en;
  sym_freq_t        ins_pair;

  sym_freq_t            slot_q [NUM_SYMBOLS];
  logic [NUM_SYMBOLS-1:0] gt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    drained   = (rd_ptr_q == nz_count);
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = SCAN;
          clear     = 1'b1;
        end
      end
      SCAN: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        // The cycle after the last transfer (or the first one of an empty list) is the done cycle.
        out_valid = !drained;
        done      = drained;
        if (drained) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign hs       = out_valid && bus.out_ready;
  assign ins_en   = pend_vld_q && (bus.freq_rd_data != '0);
  assign ins_pair = '{sym: pend_sym_q, freq: bus.freq_rd_data, vld: 1'b1};

  // Read data arrives one cycle after the strobe, so the address travels along with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rd_ptr_q   <= '0;
      nz_count   <= '0;
      pend_vld_q <= 1'b0;
      pend_sym_q <= '0;
    end else begin
      pend_vld_q <= rd_en;
      pend_sym_q <= addr_q;
      if (clear) begin
        addr_q   <= '0;
        rd_ptr_q <= '0;
        nz_count <= '0;
      end else begin
        if (rd_en)  addr_q   <= addr_q + SYM_W'(1);
        if (ins_en) nz_count <= nz_count + (SYM_W+1)'(1);
        if (hs)     rd_ptr_q <= rd_ptr_q + (SYM_W+1)'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SYMBOLS; i++) begin : g_slot
    sym_freq_t below_pair;
    sym_freq_t above_pair;
    logic      below_gt;

    if (i == 0) begin : g_bottom
      assign below_pair = '0;
      assign below_gt   = 1'b0;
    end else begin : g_mid_lo
      assign below_pair = slot_q[i-1];
      assign below_gt   = gt[i-1];
    end

    if (i == NUM_SYMBOLS - 1) begin : g_top
      assign above_pair = '0;
    end else begin : g_mid_hi
      assign above_pair = slot_q[i+1];
    end

    freq_list_sorter_sort_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .ins_en     (ins_en),
      .shift_dn   (hs),
      .ins_pair   (ins_pair),
      .below_pair (below_pair),
      .below_gt   (below_gt),
      .above_pair (above_pair),
      .pair       (slot_q[i]),
      .gt         (gt[i])
    );
  end

  assign bus.freq_rd_en   = rd_en;
  assign bus.freq_rd_addr = rd_en ? addr_q : '0;
  assign bus.out_valid    = out_valid;
  assign bus.out_sym      = out_valid ? slot_q[0].sym  : '0;
  assign bus.out_freq     = out_valid ? slot_q[0].freq : '0;
  assign bus.out_last     = out_valid && ((rd_ptr_q + (SYM_W+1)'(1)) == nz_count);
  assign dbg_state        = state;

endmodule
